// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the ID-stage control word through the EX, MEM and WB
// stage registers. It turns load-use hazards, taken branches and data-memory
// wait states into stall, flush and bubble actions.
// A bubble is valid=0 with every control bit and rd at 0.
// Optional feature macro: CTRL_PIPE_PERF_EN adds saturating stall and flush
// performance counters.
// id_ctrl layout, bit 9 first:
//   {AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Aluop[1:0], Imm[1:0]}
module ctrl_pipe #(
    parameter int RF_ADDR_W = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [9:0]           id_ctrl,
    input  logic [RF_ADDR_W-1:0] id_rs1,
    input  logic [RF_ADDR_W-1:0] id_rs2,
    input  logic [RF_ADDR_W-1:0] id_rd,
    input  logic                 ex_branch_taken,
    input  logic                 mem_ready,
    output logic                 stall,
    output logic                 flush_ifid,
    output logic                 ex_valid,
    output logic [9:0]           ex_ctrl,
    output logic [RF_ADDR_W-1:0] ex_rd,
    output logic                 mem_valid,
    output logic [5:0]           mem_ctrl,
    output logic [RF_ADDR_W-1:0] mem_rd,
    output logic                 mem_req,
    output logic                 wb_valid,
    output logic                 wb_regwrite,
    output logic                 wb_memtoreg,
    output logic [RF_ADDR_W-1:0] wb_rd
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]     perf_stall_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt
`endif
);

    // Per-cycle pipeline action, highest-priority hazard wins.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'b00,  // all stages move; EX takes the ID instruction
        ACT_HOLD    = 2'b01,  // memory wait: EX/MEM hold, WB takes a bubble
        ACT_FLUSH   = 2'b10,  // taken branch: EX takes a bubble, IF/ID invalidated
        ACT_BUBBLE  = 2'b11   // load-use: EX takes a bubble, front end holds
    } action_e;

    localparam logic [RF_ADDR_W-1:0] RD_ZERO = {RF_ADDR_W{1'b0}};

    logic                 ex_valid_r;
    logic [9:0]           ex_ctrl_r;
    logic [RF_ADDR_W-1:0] ex_rd_r;
    logic                 mem_valid_r;
    logic [5:0]           mem_ctrl_r;
    logic [RF_ADDR_W-1:0] mem_rd_r;
    logic                 wb_valid_r;
    logic                 wb_regwrite_r;
    logic                 wb_memtoreg_r;
    logic [RF_ADDR_W-1:0] wb_rd_r;

    logic    uses_rs2_s;
    logic    mem_access_s;
    logic    mem_wait_s;
    logic    br_flush_s;
    logic    load_use_s;
    action_e action_s;
    logic    stall_s;
    logic    flush_s;

    // Hazard detection from the current stage registers and the ID operands.
    always_comb begin
        uses_rs2_s   = (id_ctrl[1:0] == 2'b11) | id_ctrl[5] | id_ctrl[4];
        mem_access_s = mem_valid_r & (mem_ctrl_r[2] | mem_ctrl_r[1]);
        mem_wait_s   = mem_access_s & ~mem_ready;
        br_flush_s   = ex_valid_r & ex_ctrl_r[4] & ex_branch_taken;
        load_use_s   = ex_valid_r & ex_ctrl_r[6] & (ex_rd_r != RD_ZERO) & id_valid &
                       ((ex_rd_r == id_rs1) | (uses_rs2_s & (ex_rd_r == id_rs2)));
    end

    // Priority selection of the action plus the stall/flush strobes (quiet in reset).
    always_comb begin
        action_s = ACT_ADVANCE;
        stall_s  = 1'b0;
        flush_s  = 1'b0;
        if (mem_wait_s) begin
            action_s = ACT_HOLD;
        end else if (br_flush_s) begin
            action_s = ACT_FLUSH;
        end else if (load_use_s) begin
            action_s = ACT_BUBBLE;
        end else begin
            action_s = ACT_ADVANCE;
        end
        case (action_s)
            ACT_HOLD:    stall_s = rst_n;
            ACT_BUBBLE:  stall_s = rst_n;
            ACT_FLUSH:   flush_s = rst_n;
            ACT_ADVANCE: stall_s = 1'b0;
            default: begin
                stall_s = 1'b0;
                flush_s = 1'b0;
            end
        endcase
    end

    // Stage registers: hold, bubble or advance according to the selected action.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_r    <= 1'b0;
            ex_ctrl_r     <= 10'd0;
            ex_rd_r       <= RD_ZERO;
            mem_valid_r   <= 1'b0;
            mem_ctrl_r    <= 6'd0;
            mem_rd_r      <= RD_ZERO;
            wb_valid_r    <= 1'b0;
            wb_regwrite_r <= 1'b0;
            wb_memtoreg_r <= 1'b0;
            wb_rd_r       <= RD_ZERO;
        end else begin
            case (action_s)
                ACT_HOLD: begin
                    // EX and MEM keep their contents; WB drains a bubble.
                    wb_valid_r    <= 1'b0;
                    wb_regwrite_r <= 1'b0;
                    wb_memtoreg_r <= 1'b0;
                    wb_rd_r       <= RD_ZERO;
                end
                ACT_FLUSH, ACT_BUBBLE, ACT_ADVANCE: begin
                    // EX only accepts the ID instruction on a clean advance.
                    if ((action_s == ACT_ADVANCE) && id_valid) begin
                        ex_valid_r <= 1'b1;
                        ex_ctrl_r  <= id_ctrl;
                        ex_rd_r    <= id_rd;
                    end else begin
                        ex_valid_r <= 1'b0;
                        ex_ctrl_r  <= 10'd0;
                        ex_rd_r    <= RD_ZERO;
                    end
                    mem_valid_r   <= ex_valid_r;
                    mem_ctrl_r    <= ex_ctrl_r[9:4];
                    mem_rd_r      <= ex_rd_r;
                    wb_valid_r    <= mem_valid_r;
                    // Writes to x0 are suppressed here so the register file never sees them.
                    wb_regwrite_r <= mem_valid_r & mem_ctrl_r[3] & (mem_rd_r != RD_ZERO);
                    wb_memtoreg_r <= mem_ctrl_r[4];
                    wb_rd_r       <= mem_rd_r;
                end
                default: begin
                    ex_valid_r    <= 1'b0;
                    ex_ctrl_r     <= 10'd0;
                    ex_rd_r       <= RD_ZERO;
                    mem_valid_r   <= 1'b0;
                    mem_ctrl_r    <= 6'd0;
                    mem_rd_r      <= RD_ZERO;
                    wb_valid_r    <= 1'b0;
                    wb_regwrite_r <= 1'b0;
                    wb_memtoreg_r <= 1'b0;
                    wb_rd_r       <= RD_ZERO;
                end
            endcase
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] perf_stall_cnt_r;
    logic [CNT_W-1:0] perf_flush_cnt_r;

    // Saturating counters of stall and flush cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt_r <= {CNT_W{1'b0}};
            perf_flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (perf_stall_cnt_r != CNT_MAX)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_s && (perf_flush_cnt_r != CNT_MAX)) begin
                perf_flush_cnt_r <= perf_flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_r;
    assign perf_flush_cnt = perf_flush_cnt_r;
`endif

    assign stall       = stall_s;
    assign flush_ifid  = flush_s;
    assign mem_req     = mem_access_s;
    assign ex_valid    = ex_valid_r;
    assign ex_ctrl     = ex_ctrl_r;
    assign ex_rd       = ex_rd_r;
    assign mem_valid   = mem_valid_r;
    assign mem_ctrl    = mem_ctrl_r;
    assign mem_rd      = mem_rd_r;
    assign wb_valid    = wb_valid_r;
    assign wb_regwrite = wb_regwrite_r;
    assign wb_memtoreg = wb_memtoreg_r;
    assign wb_rd       = wb_rd_r;

endmodule
